neuro_load_ctrl: RTL and testbench
==================================

Name: neuro_load_ctrl

Overview:
- Frame parser and load sequencer between the UART receiver and the neuron weight/input array.
- Consumes received bytes, validates a framed load command and issues sequential byte writes into the array.
- Pulses load_arr when a frame completes and exposes a 5-bit state code for the received_state debug pins.

Parameters:
ADDR_W, 6, array write address width; addresses wrap modulo 2^ADDR_W
MAX_LEN, 32, maximum payload bytes per frame (1..255)
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 24'd10_000_000, inter-byte idle limit while a frame is open

Ports:
CLK  input  1  clock
RESET  input  1  asynchronous, active-low reset
rx_valid  input  1  one-cycle strobe, rx_data valid
rx_data  input  8  received byte
wr_en  output  1  one-cycle array write strobe
wr_sel  output  1  0 = weight bank, 1 = input bank
wr_addr  output  ADDR_W  array write address
wr_data  output  8  array write data
load_arr  output  1  one-cycle pulse, frame accepted
busy  output  1  high in any state other than IDLE
frame_err  output  1  sticky error flag
received_state  output  5  {frame_err, state_code[3:0]}

Behaviour:
- Reset (RESET low, asynchronous): state IDLE; all outputs 0; internal counters, address, length and checksum cleared.
- Frame format: SYNC, CMD, ADDR, LEN, LEN payload bytes, then [CHK] (CHK only with feature).
- State codes: IDLE=0, CMD=1, ADDR=2, LEN=3, DATA=4, CHK=5, DONE=6, ERR=7.
- IDLE: rx_valid with rx_data==SYNC_BYTE -> CMD and clears frame_err. Any other byte is dropped; no error.
- CMD: CMD[7:1] must be 0, else ERR. Otherwise wr_sel<=CMD[0] (held until the next accepted CMD) -> ADDR.
- ADDR: start address <= rx_data[ADDR_W-1:0] -> LEN.
- LEN: 0 or >MAX_LEN -> ERR. Otherwise store the length -> DATA.
- DATA, per payload byte:
  - wr_en=1 exactly one cycle after the rx_valid cycle, with wr_data = that byte and wr_addr = current address.
  - Address then increments; ADDR_W-bit wrap (e.g. 63 -> 0) is legal, not an error.
- After the LEN-th payload byte -> DONE, or -> CHK with the feature.
- DONE: load_arr=1 for one cycle, then IDLE. load_arr rises one cycle after the last wr_en.
- ERR: frame_err<=1 (sticky), one cycle, then IDLE. No load_arr. Writes already issued are not rolled back.
- Timeout: in CMD, ADDR, LEN, DATA or CHK, an idle counter reloads on each rx_valid. Reaching TIMEOUT_CYCLES -> ERR.
- rx_valid in DONE or ERR: byte dropped; it is not re-parsed as SYNC.
- wr_en and load_arr are never high in the same cycle.
- RESET low mid-frame: immediate IDLE, outputs 0. A partial frame never produces load_arr.
- busy=1 whenever state != IDLE.

Optional Feature:
- Macro: NEUROCORE_CHECKSUM_EN.
- Defined:
  - A running XOR of CMD, ADDR, LEN and all payload bytes is kept.
  - After the last payload byte the FSM enters CHK. The next byte must equal the running XOR: match -> DONE; mismatch -> ERR.
  - Payload writes are still issued as the bytes arrive.
- Undefined: no CHK state and no XOR logic; DATA -> DONE directly. State code 5 is unused.

Test Plan:
- Frame A5 00 10 03 11 22 33 -> wr_en pulses at addr 0x10/0x11/0x12 with data 11/22/33, wr_sel=0; load_arr one cycle after the third write; frame_err=0.
- Frame A5 01 3E 03 AA BB CC -> addresses 0x3E, 0x3F, 0x00 (wrap); wr_sel=1; load_arr pulses.
- Error frames:
  - LEN=0 -> no wr_en, frame_err=1, received_state=5'b10000 after return to IDLE.
  - CMD=0x02 -> same response.
  - A following valid SYNC clears frame_err.
- Timeout: send A5 00 00 02 11, then silence for TIMEOUT_CYCLES (bench overrides to 100) -> one write only, frame_err=1, no load_arr, busy=0. Assert RESET mid-DATA in a second run -> all outputs 0 immediately.
- Junk bytes 00 FF 5A in IDLE -> ignored, busy=0, no frame_err; then a valid frame loads normally.
- With NEUROCORE_CHECKSUM_EN: A5 00 00 01 7E 7F -> load_arr pulses; CHK byte 7E instead of 7F -> frame_err=1, no load_arr.

Source files
------------

// File: rtl/neuro_load_ctrl.sv
// neuro_load_ctrl: frame parser and load sequencer between the UART receiver
// and the neuron weight/input array.
// Frame: SYNC CMD ADDR LEN payload[LEN] [CHK]
// Optional build macro NEUROCORE_CHECKSUM_EN adds a trailing XOR checksum byte.
//
// state | meaning
// IDLE  | waiting for SYNC_BYTE, other bytes dropped
// CMD   | expecting command byte (bit 0 selects bank)
// ADDR  | expecting start address
// LEN   | expecting payload length (1..MAX_LEN)
// DATA  | payload bytes, one array write per byte
// CHK   | expecting checksum byte (NEUROCORE_CHECKSUM_EN only)
// DONE  | frame accepted, pulse load_arr
// ERR   | frame rejected, set sticky frame_err
module neuro_load_ctrl #(
  parameter int          ADDR_W         = 6,
  parameter int          MAX_LEN        = 32,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              load_arr,
  output logic              busy,
  output logic              frame_err,
  output logic [4:0]        received_state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_CMD  = 4'd1,
    S_ADDR = 4'd2,
    S_LEN  = 4'd3,
    S_DATA = 4'd4,
`ifdef NEUROCORE_CHECKSUM_EN
    S_CHK  = 4'd5,
`endif
    S_DONE = 4'd6,
    S_ERR  = 4'd7
  } state_t;

  localparam logic [23:0] TMR_RELOAD = TIMEOUT_CYCLES - 24'd1;
  localparam logic [7:0]  MAX_LEN_B  = 8'(MAX_LEN);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        remaining;
  logic [23:0]       tmr;
  logic              frame_open;
  logic              tmr_expired;
`ifdef NEUROCORE_CHECKSUM_EN
  logic [7:0]        chk_acc;
`endif

  // A frame is open in every state that is waiting on the next byte.
  always_comb begin
    frame_open = 1'b0;
    case (state)
      S_CMD, S_ADDR, S_LEN, S_DATA: frame_open = 1'b1;
`ifdef NEUROCORE_CHECKSUM_EN
      S_CHK:                        frame_open = 1'b1;
`endif
      default:                      frame_open = 1'b0;
    endcase
  end

  assign tmr_expired    = frame_open && !rx_valid && (tmr == 24'd0);
  assign busy           = (state != S_IDLE);
  assign received_state = {frame_err, state};

  // Inter-byte idle down-counter; held at reload whenever no frame is open.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tmr <= 24'd0;
    end else if (!frame_open || rx_valid) begin
      tmr <= TMR_RELOAD;
    end else if (tmr != 24'd0) begin
      tmr <= tmr - 24'd1;
    end
  end

  // Frame parser FSM with registered write/load outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_IDLE;
      wr_en     <= 1'b0;
      wr_sel    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
      load_arr  <= 1'b0;
      frame_err <= 1'b0;
      addr      <= '0;
      remaining <= 8'h00;
`ifdef NEUROCORE_CHECKSUM_EN
      chk_acc   <= 8'h00;
`endif
    end else begin
      wr_en    <= 1'b0;
      load_arr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            frame_err <= 1'b0;
            state     <= S_CMD;
          end
        end
        S_CMD: begin
          if (rx_valid) begin
            if (rx_data[7:1] != 7'd0) begin
              state <= S_ERR;
            end else begin
              wr_sel <= rx_data[0];
`ifdef NEUROCORE_CHECKSUM_EN
              chk_acc <= rx_data;
`endif
              state  <= S_ADDR;
            end
          end else if (tmr_expired) begin
            state <= S_ERR;
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            addr  <= rx_data[ADDR_W-1:0];
`ifdef NEUROCORE_CHECKSUM_EN
            chk_acc <= chk_acc ^ rx_data;
`endif
            state <= S_LEN;
          end else if (tmr_expired) begin
            state <= S_ERR;
          end
        end
        S_LEN: begin
          if (rx_valid) begin
            if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
              state <= S_ERR;
            end else begin
              remaining <= rx_data;
`ifdef NEUROCORE_CHECKSUM_EN
              chk_acc   <= chk_acc ^ rx_data;
`endif
              state     <= S_DATA;
            end
          end else if (tmr_expired) begin
            state <= S_ERR;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            wr_en     <= 1'b1;
            wr_data   <= rx_data;
            wr_addr   <= addr;
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - 8'd1;
`ifdef NEUROCORE_CHECKSUM_EN
            chk_acc   <= chk_acc ^ rx_data;
            if (remaining == 8'd1) state <= S_CHK;
`else
            if (remaining == 8'd1) state <= S_DONE;
`endif
          end else if (tmr_expired) begin
            state <= S_ERR;
          end
        end
`ifdef NEUROCORE_CHECKSUM_EN
        S_CHK: begin
          if (rx_valid) begin
            state <= (rx_data == chk_acc) ? S_DONE : S_ERR;
          end else if (tmr_expired) begin
            state <= S_ERR;
          end
        end
`endif
        S_DONE: begin
          load_arr <= 1'b1;
          state    <= S_IDLE;
        end
        S_ERR: begin
          frame_err <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuro_load_ctrl.sv
// Directed bench for neuro_load_ctrl (timeout shortened to 100 cycles).
module tb_neuro_load_ctrl;

  localparam int ADDR_W = 6;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              load_arr;
  logic              busy;
  logic              frame_err;
  logic [4:0]        received_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int load_cnt = 0;
  int last_wr_cyc = -1;
  int last_load_cyc = -1;
  int overlap = 0;
  logic [14:0] wlog[$];
  logic [7:0]  frm[$];
  bit          add_chk;

  neuro_load_ctrl #(
    .ADDR_W(ADDR_W),
    .MAX_LEN(32),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .wr_en(wr_en),
    .wr_sel(wr_sel),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .load_arr(load_arr),
    .busy(busy),
    .frame_err(frame_err),
    .received_state(received_state)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Log array writes and load pulses, sampled mid-cycle.
  always @(negedge CLK) begin
    if (wr_en) begin
      wlog.push_back({wr_sel, wr_addr, wr_data});
      last_wr_cyc = cyc;
    end
    if (load_arr) begin
      load_cnt++;
      last_load_cyc = cyc;
    end
    if (wr_en && load_arr) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge CLK); #1;
    rx_valid = 1'b0;
  endtask

  // Sends frm; with add_chk a trailing XOR of all bytes after SYNC is appended.
  // Without the checksum build that extra byte lands in IDLE and must be dropped.
  task automatic send_frm();
    logic [7:0] x;
    x = 8'h00;
    foreach (frm[i]) begin
      send_byte(frm[i]);
      if (i > 0) x = x ^ frm[i];
    end
    if (add_chk) send_byte(x);
    frm.delete();
  endtask

  task automatic clear_log();
    wlog.delete();
    load_cnt = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    // reset state
    wait_cyc(3);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_sel", wr_sel, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_load_arr", load_arr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_state", received_state, 5'b00000);
    @(negedge CLK);
    RESET = 1'b1;

    // junk bytes in IDLE
    clear_log();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    wait_cyc(3);
    chk("junk_busy", busy, 0);
    chk("junk_err", frame_err, 0);
    chk("junk_writes", wlog.size(), 0);

    // frame A: weight bank, addr 0x10
    clear_log();
    add_chk = 1'b1;
    frm = '{8'hA5, 8'h00, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33};
    send_frm();
    wait_cyc(4);
    chk("a_nwr", wlog.size(), 3);
    chk("a_wr0", wlog[0], {1'b0, 6'h10, 8'h11});
    chk("a_wr1", wlog[1], {1'b0, 6'h11, 8'h22});
    chk("a_wr2", wlog[2], {1'b0, 6'h12, 8'h33});
    chk("a_load", load_cnt, 1);
`ifndef NEUROCORE_CHECKSUM_EN
    chk("a_load_lat", last_load_cyc, last_wr_cyc + 1);
`endif
    chk("a_err", frame_err, 0);
    chk("a_busy", busy, 0);

    // frame B: input bank, address wrap 3F -> 00
    clear_log();
    frm = '{8'hA5, 8'h01, 8'h3E, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    send_frm();
    wait_cyc(4);
    chk("b_nwr", wlog.size(), 3);
    chk("b_wr0", wlog[0], {1'b1, 6'h3E, 8'hAA});
    chk("b_wr1", wlog[1], {1'b1, 6'h3F, 8'hBB});
    chk("b_wr2", wlog[2], {1'b1, 6'h00, 8'hCC});
    chk("b_load", load_cnt, 1);
`ifndef NEUROCORE_CHECKSUM_EN
    chk("b_load_lat", last_load_cyc, last_wr_cyc + 1);
`endif

    // LEN = 0
    clear_log();
    add_chk = 1'b0;
    frm = '{8'hA5, 8'h00, 8'h10, 8'h00};
    send_frm();
    wait_cyc(3);
    chk("len0_nwr", wlog.size(), 0);
    chk("len0_err", frame_err, 1);
    chk("len0_state", received_state, 5'b10000);
    chk("len0_load", load_cnt, 0);

    // LEN above MAX_LEN
    frm = '{8'hA5, 8'h00, 8'h10, 8'h21};
    send_frm();
    wait_cyc(3);
    chk("lenbig_err", frame_err, 1);
    chk("lenbig_nwr", wlog.size(), 0);

    // SYNC clears frame_err, then bad CMD 0x02
    send_byte(8'hA5);
    chk("sync_clr_err", frame_err, 0);
    chk("sync_state", received_state, 5'b00001);
    chk("sync_busy", busy, 1);
    send_byte(8'h02);
    wait_cyc(3);
    chk("cmd_err", frame_err, 1);
    chk("cmd_state", received_state, 5'b10000);
    chk("cmd_nwr", wlog.size(), 0);

    // timeout mid-DATA
    clear_log();
    frm = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h11};
    send_frm();
    chk("to_busy_open", busy, 1);
    wait_cyc(60);
    chk("to_busy_early", busy, 1);
    chk("to_err_early", frame_err, 0);
    wait_cyc(70);
    chk("to_nwr", wlog.size(), 1);
    chk("to_wr0", wlog[0], {1'b0, 6'h00, 8'h11});
    chk("to_err", frame_err, 1);
    chk("to_load", load_cnt, 0);
    chk("to_busy", busy, 0);

    // valid frame after error
    clear_log();
    add_chk = 1'b1;
    frm = '{8'hA5, 8'h00, 8'h20, 8'h01, 8'h5A};
    send_frm();
    wait_cyc(4);
    chk("rec_load", load_cnt, 1);
    chk("rec_err", frame_err, 0);
    chk("rec_wr0", wlog[0], {1'b0, 6'h20, 8'h5A});

    // reset mid-DATA
    clear_log();
    add_chk = 1'b0;
    frm = '{8'hA5, 8'h01, 8'h08, 8'h03, 8'h44, 8'h55};
    send_frm();
    chk("mid_wr_en", wr_en, 1);
    RESET = 1'b0;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_wr_sel", wr_sel, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_state", received_state, 5'b00000);
    chk("mid_rst_load", load_arr, 0);
    @(negedge CLK);
    RESET = 1'b1;
    send_byte(8'h66);
    wait_cyc(5);
    chk("mid_no_load", load_cnt, 0);
    chk("mid_idle", busy, 0);

`ifdef NEUROCORE_CHECKSUM_EN
    // checksum match
    clear_log();
    frm = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h7E, 8'h7F};
    send_frm();
    wait_cyc(4);
    chk("ck_good_load", load_cnt, 1);
    chk("ck_good_err", frame_err, 0);
    // checksum mismatch
    clear_log();
    frm = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h7E, 8'h7E};
    send_frm();
    wait_cyc(4);
    chk("ck_bad_load", load_cnt, 0);
    chk("ck_bad_err", frame_err, 1);
    chk("ck_bad_nwr", wlog.size(), 1);
`endif

    chk("no_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
